// File: rtl/fir_folded_ctrl_if.sv
// Handshake and datapath control bundle between the folded FIR sequencer and its neighbours.
// The slave side is the sequencer; the master side is the sample source plus the MAC datapath.
interface fir_folded_ctrl_if #(
  parameter int NB_ADDR = 3,
  parameter int NB_DROP = 8
);
  logic               sample_valid;
  logic               sample_ready;
  logic               wr_en;
  logic               wr_zero;
  logic [NB_ADDR-1:0] wr_ptr;
  logic [NB_ADDR-1:0] rd_addr;
  logic [NB_ADDR-1:0] coef_idx;
  logic               acc_clr;
  logic               acc_en;
  logic               out_valid;
  logic               drop;
  logic [NB_DROP-1:0] drop_cnt;

  modport master (
    output sample_valid,
    input  sample_ready, wr_en, wr_zero, wr_ptr, rd_addr, coef_idx,
           acc_clr, acc_en, out_valid, drop, drop_cnt
  );

  modport slave (
    input  sample_valid,
    output sample_ready, wr_en, wr_zero, wr_ptr, rd_addr, coef_idx,
           acc_clr, acc_en, out_valid, drop, drop_cnt
  );
endinterface

// File: rtl/fir_folded_ctrl.sv
// Sequencer for a folded FIR: one MAC per cycle, N_TAPS cycles per sample, delay line zeroed after reset.
// All outputs are registered and always describe the state the controller is currently in.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   S_INIT  | zero-fill sweep of the delay line, one address per cycle
//   S_IDLE  | ready for a sample strobe
//   S_WRITE | newest sample written at wr_ptr
//   S_MAC   | one tap per cycle, newest sample first
//   S_DONE  | accumulator holds the finished output, pointer advances
module fir_folded_ctrl #(
  parameter int N_TAPS  = 6,
  parameter int NB_ADDR = 3,
  parameter int NB_DROP = 8
) (
  input logic              clk,
  input logic              rst,
  fir_folded_ctrl_if.slave bus
);

  localparam int                 CW        = $clog2(N_TAPS + 1);
  localparam logic [CW-1:0]      CNT_TAPS  = CW'(N_TAPS);
  localparam logic [CW-1:0]      CNT_LAST  = CW'(N_TAPS - 1);
  localparam logic [NB_ADDR-1:0] ADDR_LAST = NB_ADDR'(N_TAPS - 1);
  localparam logic [NB_DROP-1:0] DROP_MAX  = '1;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_IDLE  = 3'd1,
    S_WRITE = 3'd2,
    S_MAC   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ready_q, ready_d;
  logic               wr_en_q, wr_en_d;
  logic               wr_zero_q, wr_zero_d;
  logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d;
  logic [NB_ADDR-1:0] rd_addr_q, rd_addr_d;
  logic [NB_ADDR-1:0] coef_idx_q, coef_idx_d;
  logic               acc_clr_q, acc_clr_d;
  logic               acc_en_q, acc_en_d;
  logic               out_valid_q, out_valid_d;
  logic               drop_q, drop_d;
  logic [NB_DROP-1:0] drop_cnt_q, drop_cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_zero_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_addr_q   <= '0;
      coef_idx_q  <= '0;
      acc_clr_q   <= 1'b0;
      acc_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= ready_d;
      wr_en_q     <= wr_en_d;
      wr_zero_q   <= wr_zero_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_addr_q   <= rd_addr_d;
      coef_idx_q  <= coef_idx_d;
      acc_clr_q   <= acc_clr_d;
      acc_en_q    <= acc_en_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ready_d     = 1'b0;
    wr_en_d     = 1'b0;
    wr_zero_d   = 1'b0;
    wr_ptr_d    = wr_ptr_q;
    rd_addr_d   = rd_addr_q;
    coef_idx_d  = coef_idx_q;
    acc_clr_d   = 1'b0;
    acc_en_d    = 1'b0;
    out_valid_d = 1'b0;
    drop_d      = 1'b0;
    drop_cnt_d  = drop_cnt_q;

    case (state_q)
      // cnt_q == N_TAPS marks the end of the sweep; the reset value 0 is the first address
      S_INIT: begin
        if (cnt_q == CNT_TAPS) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          ready_d  = 1'b1;
          wr_ptr_d = '0;
        end else begin
          cnt_d     = cnt_q + CW'(1);
          wr_en_d   = 1'b1;
          wr_zero_d = 1'b1;
          wr_ptr_d  = NB_ADDR'(cnt_q);
        end
      end
      S_IDLE: begin
        if (bus.sample_valid) begin
          state_d = S_WRITE;
          wr_en_d = 1'b1;
        end else begin
          ready_d = 1'b1;
        end
      end
      S_WRITE: begin
        state_d    = S_MAC;
        cnt_d      = '0;
        acc_en_d   = 1'b1;
        acc_clr_d  = 1'b1;
        coef_idx_d = '0;
        rd_addr_d  = wr_ptr_q;
      end
      S_MAC: begin
        if (cnt_q == CNT_LAST) begin
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else begin
          cnt_d      = cnt_q + CW'(1);
          acc_en_d   = 1'b1;
          coef_idx_d = coef_idx_q + NB_ADDR'(1);
          rd_addr_d  = (rd_addr_q == '0) ? ADDR_LAST : rd_addr_q - NB_ADDR'(1);
        end
      end
      S_DONE: begin
        state_d  = S_IDLE;
        ready_d  = 1'b1;
        wr_ptr_d = (wr_ptr_q == ADDR_LAST) ? '0 : wr_ptr_q + NB_ADDR'(1);
      end
      default: begin
        state_d = S_INIT;
        cnt_d   = '0;
      end
    endcase

    if (bus.sample_valid && (state_q != S_IDLE)) begin
      drop_d = 1'b1;
      if (drop_cnt_q != DROP_MAX) drop_cnt_d = drop_cnt_q + NB_DROP'(1);
    end
  end

  assign bus.sample_ready = ready_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_zero      = wr_zero_q;
  assign bus.wr_ptr       = wr_ptr_q;
  assign bus.rd_addr      = rd_addr_q;
  assign bus.coef_idx     = coef_idx_q;
  assign bus.acc_clr      = acc_clr_q;
  assign bus.acc_en       = acc_en_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.drop         = drop_q;
  assign bus.drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_fir_folded_ctrl.sv
// Bench for fir_folded_ctrl: directed scenarios with literal expectations, then random strobes/resets
// checked every cycle against a schedule model and a direct-convolution FIR reference.
module tb_fir_folded_ctrl;
  localparam int N    = 6;
  localparam int NA   = 3;
  localparam int ND   = 8;
  localparam int DMAX = (1 << ND) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] sample_data = '0;

  fir_folded_ctrl_if #(.NB_ADDR(NA), .NB_DROP(ND)) bus ();
  fir_folded_ctrl #(.N_TAPS(N), .NB_ADDR(NA), .NB_DROP(ND)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Folded MAC datapath driven by the controller outputs
  int          coef[N] = '{1, 2, 3, 3, 2, 1};
  longint      ram[N];
  longint      acc = 0;
  logic [15:0] held = '0;
  longint      res_q[$];

  always @(posedge clk) begin
    if (!rst && bus.sample_valid === 1'b1 && bus.sample_ready === 1'b1) held <= sample_data;
    if (bus.wr_en === 1'b1) ram[bus.wr_ptr] <= (bus.wr_zero === 1'b1) ? 64'sd0 : longint'(held);
    if (bus.acc_en === 1'b1)
      acc <= ((bus.acc_clr === 1'b1) ? 64'sd0 : acc) + longint'(coef[bus.coef_idx]) * ram[bus.rd_addr];
  end

  // Schedule model: reset release starts an N-cycle sweep; an accepted sample at c occupies c+1..c+N+2
  int     started = 0;
  int     init_start = 1 << 30;
  int     samp_start = -1;
  int     p = 0, next_p = 0;
  int     drops_exp = 0;
  bit     drop_exp = 1'b0;
  longint hist[$];

  function automatic longint fir_exp();
    longint y = 0;
    for (int k = 0; k < N; k++)
      if (k < hist.size()) y += longint'(coef[k]) * hist[hist.size() - 1 - k];
    return y;
  endfunction

  bit e_wr, e_zero, e_acc, e_clr, e_ov, e_rdy;
  int e_ptr, e_rd, e_k, d;

  always @(negedge clk) begin
    e_wr = 0; e_zero = 0; e_acc = 0; e_clr = 0; e_ov = 0; e_rdy = 0;
    e_ptr = 0; e_rd = 0; e_k = 0;
    if (cyc >= init_start && cyc < init_start + N) begin
      e_wr = 1; e_zero = 1; e_ptr = cyc - init_start;
    end else if (cyc >= init_start + N) begin
      if (samp_start < 0) e_rdy = 1;
      else begin
        d = cyc - samp_start;
        if (d == 0) begin e_wr = 1; e_ptr = p; end
        else if (d <= N) begin e_acc = 1; e_k = d - 1; e_clr = (d == 1); e_rd = (p - e_k + N) % N; end
        else if (d == N + 1) e_ov = 1;
        else e_rdy = 1;
      end
    end
    if (started != 0) begin
      chk("sample_ready", bus.sample_ready, e_rdy);
      chk("wr_en", bus.wr_en, e_wr);
      chk("acc_en", bus.acc_en, e_acc);
      chk("acc_clr", bus.acc_clr, e_clr);
      chk("out_valid", bus.out_valid, e_ov);
      chk("drop", bus.drop, drop_exp);
      chk("drop_cnt", bus.drop_cnt, drops_exp);
      if (e_wr) begin
        chk("wr_zero", bus.wr_zero, e_zero);
        chk("wr_ptr", bus.wr_ptr, e_ptr);
      end
      if (e_rdy) chk("idle_wr_ptr", bus.wr_ptr, next_p);
      if (e_acc) begin
        chk("coef_idx", bus.coef_idx, e_k);
        chk("rd_addr", bus.rd_addr, e_rd);
      end
      if (e_ov) chk("fir_result", acc, fir_exp());
      if (bus.out_valid === 1'b1) res_q.push_back(acc);
    end
    if (rst) begin
      started = 1; init_start = cyc + 2; samp_start = -1; next_p = 0;
      drops_exp = 0; drop_exp = 0; hist.delete();
    end else if (started != 0) begin
      drop_exp = 0;
      if (bus.sample_valid) begin
        if (e_rdy) begin
          samp_start = cyc + 1; p = next_p; next_p = (p + 1) % N;
          hist.push_back(longint'(sample_data));
        end else begin
          drop_exp = 1;
          if (drops_exp < DMAX) drops_exp++;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int     rd_lit[N] = '{0, 5, 4, 3, 2, 1};
  longint res_lit[7] = '{64'h4000, 64'h8000, 64'hC000, 64'hC000, 64'h8000, 64'h4000, 64'h0};
  int     ptr_lit[7] = '{0, 1, 2, 3, 4, 5, 0};
  int     ptr_seen[$];

  initial begin
    bus.sample_valid = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // zero sweep after reset release
    for (int i = 1; i <= 7; i++) begin
      step();
      if (i <= 6) begin
        chk("lit_init_wr_en", bus.wr_en, 1);
        chk("lit_init_ptr", bus.wr_ptr, i - 1);
      end else chk("lit_init_ready", bus.sample_ready, 1);
    end

    // impulse then zeros through the folded datapath
    bus.sample_valid = 1'b1; sample_data = 16'h4000;
    step();
    bus.sample_valid = 1'b0;
    chk("lit_write_ptr", bus.wr_ptr, 0);
    for (int k = 0; k < N; k++) begin
      step();
      chk("lit_coef", bus.coef_idx, k);
      chk("lit_rd_addr", bus.rd_addr, rd_lit[k]);
      chk("lit_acc_clr", bus.acc_clr, (k == 0));
    end
    step();
    chk("lit_out_valid", bus.out_valid, 1);
    step();
    chk("lit_ready_after", bus.sample_ready, 1);
    chk("lit_ptr_after", bus.wr_ptr, 1);
    for (int s = 0; s < 6; s++) begin
      bus.sample_valid = 1'b1; sample_data = '0;
      step();
      bus.sample_valid = 1'b0;
      repeat (N + 2) step();
    end
    chk("lit_res_count", res_q.size(), 7);
    for (int i = 0; i < 7 && i < res_q.size(); i++) chk("lit_impulse_out", res_q[i], res_lit[i]);

    // strobe during MAC tap 3 is dropped without disturbing the sequence
    bus.sample_valid = 1'b1; sample_data = 16'h0123;
    step();
    bus.sample_valid = 1'b0;
    repeat (4) step();
    bus.sample_valid = 1'b1;
    step();
    bus.sample_valid = 1'b0;
    chk("lit_drop", bus.drop, 1);
    chk("lit_drop_cnt", bus.drop_cnt, 1);
    repeat (2) step();
    chk("lit_out_valid_kept", bus.out_valid, 1);
    step();

    // reset during MAC tap 2 aborts and restarts the sweep
    bus.sample_valid = 1'b1; sample_data = 16'h0777;
    step();
    bus.sample_valid = 1'b0;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("lit_abort_acc_en", bus.acc_en, 0);
    chk("lit_abort_out_valid", bus.out_valid, 0);
    chk("lit_abort_drop_cnt", bus.drop_cnt, 0);
    for (int i = 0; i < N; i++) begin
      step();
      chk("lit_resweep_ptr", bus.wr_ptr, i);
      chk("lit_resweep_zero", bus.wr_zero, 1);
    end
    step();
    chk("lit_resweep_ready", bus.sample_ready, 1);
    chk("lit_resweep_ptr0", bus.wr_ptr, 0);

    // strobe held high: one accept per N+3 cycles, pointer wraps
    bus.sample_valid = 1'b1;
    for (int i = 0; i < 7 * (N + 3); i++) begin
      sample_data = 16'($urandom);
      step();
      if (bus.wr_en === 1'b1 && bus.wr_zero === 1'b0) ptr_seen.push_back(int'(bus.wr_ptr));
    end
    chk("lit_held_drop_cnt", bus.drop_cnt, 56);
    chk("lit_held_writes", ptr_seen.size(), 7);
    for (int i = 0; i < 7 && i < ptr_seen.size(); i++) chk("lit_held_ptr", ptr_seen[i], ptr_lit[i]);
    repeat (300) begin
      sample_data = 16'($urandom);
      step();
    end
    chk("lit_drop_saturated", bus.drop_cnt, DMAX);
    bus.sample_valid = 1'b0;
    repeat (N + 3) step();

    // random strobes, data and occasional resets
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 249) == 0);
      bus.sample_valid = ($urandom_range(0, 99) < 35);
      sample_data = 16'($urandom);
      step();
    end
    rst = 1'b0;
    bus.sample_valid = 1'b0;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
